seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a DIGITS-digit common-anode/common-cathode seven-segment display. Latches a packed hex word on a load strobe and decodes each 4-bit nibble to segments: 0-9 as digits, A-F as hex letters. It scans one digit at a time at a programmable refresh rate, with inter-digit ghosting guard, leading-zero blanking and per-digit decimal points. It sits between the core datapath and the board display pins, replacing per-digit static decoding where pin count is limited.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned (1..8).
- DIV_WIDTH, 10: prescaler width; each digit slot lasts 2^DIV_WIDTH cycles.
- GUARD, 2: cycles at the start of each slot with all outputs inactive (0 ≤ GUARD < 2^DIV_WIDTH).
- ACTIVE_LOW, 0: 1 inverts segments, dp_out and digit_en (active level 0).
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- value  in  4*DIGITS  packed nibbles, nibble i = digit i, digit 0 least significant.
- dp  in  DIGITS  decimal point request per digit.
- load  in  1  when 1 at an edge, value and dp are captured into the shadow registers.
- display_en  in  1  0 forces all outputs inactive; scanning continues.
- segments  out  7  bit0 = a (top), bit1 = b, bit2 = c, bit3 = d (bottom), bit4 = e, bit5 = f, bit6 = g (middle); registered.
- dp_out  out  1  decimal point of the active digit; registered.
- digit_en  out  DIGITS  one-hot digit select, or all inactive; registered.
- frame_tick  out  1  one-cycle pulse after each full scan.

## Operation
- State: prescaler pre[DIV_WIDTH-1:0], index idx (0..DIGITS-1), shadow_val, shadow_dp, output registers.
- pre increments every cycle and wraps 2^DIV_WIDTH-1 -> 0. On that wrap edge idx increments; DIGITS-1 wraps to 0.
- Decode table, hex, active-high, bit6..0: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67 A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blanking (BLANK_LZ=1): digit i is blanked (segments inactive) iff nibbles i..DIGITS-1 are all zero and i ≠ 0. Digit 0 is never blanked, so value 0 shows "0".
- dp_out = shadow_dp[idx] regardless of blanking.
- Next-output rule, evaluated from current state each edge:
  - All outputs are inactive if display_en=0 or pre < GUARD.
  - Otherwise digit_en has only bit idx active, segments shows the decoded or blanked nibble idx, and dp_out follows shadow_dp[idx].
- ACTIVE_LOW=1 inverts all three outputs at the register input. "Inactive" then means all ones.
- frame_tick: registered 1 for exactly one cycle after the edge on which idx wraps DIGITS-1 -> 0. It never pulses from reset alone.
- DIGITS=1: idx is constant 0, and frame_tick pulses on every pre wrap.

## Timing
- Reset:
  - pre=0, idx=0, shadow_val=0, shadow_dp=0, frame_tick=0.
  - segments, dp_out and digit_en are all inactive (all 0, or all 1 when ACTIVE_LOW=1).
  - Reset overrides load and applies mid-scan with the same result.
- Output latency: one cycle. Outputs after edge t reflect pre, idx and shadow as they stood before edge t.
- Load: value captured at edge t appears on outputs from edge t+1, in whatever slot is current. Load does not reset pre or idx. Back-to-back loads are allowed; the last one wins.
- Slot n, starting at pre=0 with idx=n: outputs are inactive for cycles 1..GUARD after the slot's first edge, then drive digit n for the remaining 2^DIV_WIDTH-GUARD cycles.
- Full frame = DIGITS·2^DIV_WIDTH cycles. frame_tick period equals one frame.
- display_en is sampled each edge with one-cycle effect. It has no effect on pre, idx or the shadow registers.

## Test plan
- Reset and idle: ACTIVE_LOW=0, DIGITS=4, DIV_WIDTH=3, GUARD=2. Hold reset 3 cycles, then release with no load. Required: segments/digit_en/dp_out = 0 during reset. After release, digit 0 shows 3F with digit_en=0001; digits 1-3 are blanked (segments 00) with their enable still asserted.
- Full scan: load value=16'h1A2F, dp=4'b0100. Required each slot, after GUARD: digit 0 = 71, digit 1 = 5B, digit 2 = 77 with dp_out=1, digit 3 = 06. frame_tick pulses once every 32 cycles.
- Leading-zero blanking: value=16'h0050. Required: digits 3 and 2 blank, digit 1 = 6D, digit 0 = 3F. Repeat with BLANK_LZ=0: digits 3 and 2 = 3F.
- Active-low and guard: ACTIVE_LOW=1, value=16'h8888. Required: segments=7'h00 and the active digit_en bit=0 outside guard. During the first GUARD cycles of every slot, all outputs are all-ones.
- Mid-operation events: load 16'h1234 mid-slot and observe the change one cycle later without a slot restart. Drop display_en for 5 cycles: outputs go inactive next cycle while idx keeps advancing. Assert reset mid-slot: outputs are inactive next cycle and the scan restarts at idx=0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver: latches packed hex nibbles, decodes them and
// drives one digit per prescaler slot, with guard cycles, leading-zero blanking and dp.
module seg7_scan_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIV_WIDTH  = 10,
    parameter int unsigned GUARD      = 2,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  display_en,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_tick
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_WIDTH-1:0] pre_q;
    logic [IdxW-1:0]      idx_q;
    logic [4*DIGITS-1:0]  shadow_val_q;
    logic [DIGITS-1:0]    shadow_dp_q;

    logic                 pre_wrap;
    logic                 idx_wrap;
    logic                 active;
    logic                 all_zero;
    logic [DIGITS-1:0]    lz_blank;
    logic [DIGITS-1:0]    en_oh;
    logic [3:0]           nib;
    logic                 blank_sel;
    logic                 dp_sel;
    logic [6:0]           seg_d;
    logic                 dp_d;
    logic [DIGITS-1:0]    en_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h67;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    assign pre_wrap = &pre_q;
    assign idx_wrap = (idx_q == IdxW'(DIGITS - 1));

    always_comb begin
        all_zero  = 1'b1;
        lz_blank  = '0;
        en_oh     = '0;
        nib       = 4'h0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        // Walk from the most significant digit down so all_zero covers nibbles i..DIGITS-1.
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero    = all_zero & (shadow_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = all_zero && (i != 0);
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                en_oh[i]  = 1'b1;
                nib       = shadow_val_q[4*i +: 4];
                blank_sel = lz_blank[i];
                dp_sel    = shadow_dp_q[i];
            end
        end
    end

    always_comb begin
        active = display_en && (pre_q >= DIV_WIDTH'(GUARD));
        seg_d  = (active && !(BLANK_LZ && blank_sel)) ? decode(nib) : 7'h00;
        dp_d   = active & dp_sel;
        en_d   = active ? en_oh : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            frame_tick   <= 1'b0;
            segments     <= {7{ACTIVE_LOW}};
            dp_out       <= ACTIVE_LOW;
            digit_en     <= {DIGITS{ACTIVE_LOW}};
        end else begin
            pre_q <= pre_q + 1'b1;
            if (pre_wrap) begin
                idx_q <= idx_wrap ? '0 : idx_q + 1'b1;
            end
            if (load) begin
                shadow_val_q <= value;
                shadow_dp_q  <= dp;
            end
            frame_tick <= pre_wrap && idx_wrap;
            segments   <= seg_d ^ {7{ACTIVE_LOW}};
            dp_out     <= dp_d ^ ACTIVE_LOW;
            digit_en   <= en_d ^ {DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: three instances (default, no blanking, active-low) share stimulus; edges
// are counted from reset release so every expected value is fixed by hand.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        display_en;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dpo_a, dpo_b, dpo_c;
    logic [3:0] en_a, en_b, en_c;
    logic       ft_a, ft_b, ft_c;

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .DIV_WIDTH(3), .GUARD(2), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
        dut (.clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
             .display_en(display_en), .segments(seg_a), .dp_out(dpo_a), .digit_en(en_a),
             .frame_tick(ft_a));

    seg7_scan_driver #(.DIGITS(4), .DIV_WIDTH(3), .GUARD(2), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0))
        dut_nlz (.clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
                 .display_en(display_en), .segments(seg_b), .dp_out(dpo_b), .digit_en(en_b),
                 .frame_tick(ft_b));

    seg7_scan_driver #(.DIGITS(4), .DIV_WIDTH(3), .GUARD(2), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
        dut_al (.clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
                .display_en(display_en), .segments(seg_c), .dp_out(dpo_c), .digit_en(en_c),
                .frame_tick(ft_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    endtask

    task automatic run_to(input int k);
        while (ecnt < k) begin
            @(posedge clk);
            #1;
            ecnt++;
        end
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(posedge clk);
        #1;
        ecnt++;
        load = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        value      = 16'h0;
        dp         = 4'h0;
        load       = 1'b0;
        display_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", {25'h0, seg_a}, 32'h00);
        check("rst_en", {28'h0, en_a}, 32'h0);
        check("rst_dp", {31'h0, dpo_a}, 32'h0);
        check("rst_ft", {31'h0, ft_a}, 32'h0);
        check("rst_al", {20'h0, seg_c, dpo_c, en_c}, 32'h0FFF);
        reset = 1'b0;
        ecnt  = 0;

        // Idle after release: digit 0 shows 0, upper digits blanked but enabled
        run_to(2);  check("idle_guard_en", {28'h0, en_a}, 32'h0);
        run_to(3);  check("idle_d0_seg", {25'h0, seg_a}, 32'h3F);
                    check("idle_d0_en", {28'h0, en_a}, 32'h1);
        run_to(11); check("idle_d1", {21'h0, seg_a, en_a}, {21'h0, 7'h00, 4'b0010});
        run_to(19); check("idle_d2", {21'h0, seg_a, en_a}, {21'h0, 7'h00, 4'b0100});
        run_to(27); check("idle_d3", {21'h0, seg_a, en_a}, {21'h0, 7'h00, 4'b1000});
        run_to(31); check("ft_before", {31'h0, ft_a}, 32'h0);
        run_to(32); check("ft_frame0", {31'h0, ft_a}, 32'h1);

        // Full scan of 1A2F with dp on digit 2
        load_word(16'h1A2F, 4'b0100);
        check("ft_after", {31'h0, ft_a}, 32'h0);
        run_to(35); check("scan_d0", {20'h0, seg_a, dpo_a, en_a}, {20'h0, 7'h71, 1'b0, 4'b0001});
        run_to(43); check("scan_d1", {20'h0, seg_a, dpo_a, en_a}, {20'h0, 7'h5B, 1'b0, 4'b0010});
        run_to(51); check("scan_d2", {20'h0, seg_a, dpo_a, en_a}, {20'h0, 7'h77, 1'b1, 4'b0100});
        run_to(59); check("scan_d3", {20'h0, seg_a, dpo_a, en_a}, {20'h0, 7'h06, 1'b0, 4'b1000});
        run_to(63); check("ft_63", {31'h0, ft_a}, 32'h0);
        run_to(64); check("ft_64", {31'h0, ft_a}, 32'h1);

        // Leading-zero blanking, compared against the non-blanking instance
        load_word(16'h0050, 4'b0000);
        run_to(67); check("lz_d0", {25'h0, seg_a}, 32'h3F);
        run_to(75); check("lz_d1", {25'h0, seg_a}, 32'h6D);
        run_to(83); check("lz_d2", {25'h0, seg_a}, 32'h00);
                    check("nlz_d2", {25'h0, seg_b}, 32'h3F);
        run_to(91); check("lz_d3", {21'h0, seg_a, en_a}, {21'h0, 7'h00, 4'b1000});
                    check("nlz_d3", {25'h0, seg_b}, 32'h3F);
        run_to(96); check("ft_96", {31'h0, ft_a}, 32'h1);

        // Active-low with guard
        load_word(16'h8888, 4'b0000);
        check("al_guard1", {20'h0, seg_c, dpo_c, en_c}, 32'h0FFF);
        run_to(98);  check("al_guard2", {20'h0, seg_c, dpo_c, en_c}, 32'h0FFF);
        run_to(99);  check("al_d0", {20'h0, seg_c, dpo_c, en_c}, {20'h0, 7'h00, 1'b1, 4'b1110});
        run_to(105); check("al_guard_s1", {20'h0, seg_c, dpo_c, en_c}, 32'h0FFF);
        run_to(107); check("al_d1", {20'h0, seg_c, dpo_c, en_c}, {20'h0, 7'h00, 1'b1, 4'b1101});

        // Mid-slot load: change appears one cycle later, same digit
        run_to(131); check("mid_pre", {21'h0, seg_a, en_a}, {21'h0, 7'h7F, 4'b0001});
        load_word(16'h1234, 4'b0000);
        check("mid_lat", {25'h0, seg_a}, 32'h7F);
        run_to(133); check("mid_new", {21'h0, seg_a, en_a}, {21'h0, 7'h66, 4'b0001});

        // display_en dropped for 5 edges (141..145)
        run_to(140); check("den_before", {21'h0, seg_a, en_a}, {21'h0, 7'h4F, 4'b0010});
        display_en = 1'b0;
        run_to(141); check("den_off", {20'h0, seg_a, dpo_a, en_a}, 32'h0);
        run_to(144); check("den_off_late", {21'h0, seg_a, en_a}, 32'h0);
        run_to(145);
        display_en = 1'b1;
        run_to(147); check("den_back", {21'h0, seg_a, en_a}, {21'h0, 7'h5B, 4'b0100});

        // Reset mid-slot with a load pending: reset wins, scan restarts at digit 0
        run_to(149);
        reset = 1'b1;
        value = 16'hFFFF;
        dp    = 4'hF;
        load  = 1'b1;
        run_to(150);
        check("mrst_out", {20'h0, seg_a, dpo_a, en_a}, 32'h0);
        check("mrst_al", {20'h0, seg_c, dpo_c, en_c}, 32'h0FFF);
        check("mrst_ft", {31'h0, ft_a}, 32'h0);
        reset = 1'b0;
        load  = 1'b0;
        ecnt  = 0;
        run_to(2);  check("mrst_guard", {28'h0, en_a}, 32'h0);
        run_to(3);  check("mrst_d0", {20'h0, seg_a, dpo_a, en_a}, {20'h0, 7'h3F, 1'b0, 4'b0001});
        run_to(11); check("mrst_d1", {21'h0, seg_a, en_a}, {21'h0, 7'h00, 4'b0010});
                    check("mrst_nlz_d1", {25'h0, seg_b}, 32'h3F);
        run_to(31); check("mrst_ft31", {31'h0, ft_a}, 32'h0);
        run_to(32); check("mrst_ft32", {31'h0, ft_a}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
